// File: rtl/fmeas_gate_if.sv
// Result handshake between the gate controller and its consumer.
// The master drives result/result_valid; the slave answers with result_ready.
interface fmeas_gate_if #(
  parameter int LENGTH = 20
);
  logic [LENGTH-1:0] result;
  logic              result_valid;
  logic              result_ready;

  modport master (
    output result,
    output result_valid,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    output result_ready
  );
endinterface

// File: rtl/fmeas_gate_controller.sv
// Reference-clock gate controller for the frequency counter: clears the counter,
// issues periodic latch pulses, double-samples the latched count and emits per-gate deltas.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | measurement stopped, all outputs low
// CLR      | counter_reset held high for RST_CYCLES clocks
// WAIT     | period timer counting down to the next latch edge
// LATCH    | latch_counter high for pulse_len clocks (0 treated as 1)
// SETTLE   | let the latched count cross into this domain
// SAMPLE0  | capture first copy of cycle_count
// SAMPLE1  | capture second copy, compare, compute and deliver delta
module fmeas_gate_controller #(
  parameter int LENGTH     = 20,
  parameter int PERIOD_W   = 24,
  parameter int SETTLE     = 4,
  parameter int RST_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [3:0]          pulse_len,
  input  logic [LENGTH-1:0]   cycle_count,
  output logic                counter_reset,
  output logic                latch_counter,
  fmeas_gate_if.master        res_if,
  output logic                overrun,
  output logic                glitch,
  output logic                busy
);

  localparam int PH_MAX_A = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
  localparam int PH_MAX   = (PH_MAX_A > 16) ? PH_MAX_A : 16;
  localparam int PH_W     = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0]     PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0]     PH_RST  = PH_W'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]     PH_SET  = PH_W'(SETTLE - 1);
  localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PER_OVH = PERIOD_W'(SETTLE + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_LATCH,
    S_SETTLE,
    S_SAMPLE0,
    S_SAMPLE1
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [LENGTH-1:0]   s0_q, s0_d;
  logic [LENGTH-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic [LENGTH-1:0]   result_q, result_d;
  logic                rv_q, rv_d;
  logic                overrun_d, glitch_d;
  logic                counter_reset_d, latch_counter_d, busy_d;

  logic [3:0]          pl_eff;
  logic [PERIOD_W-1:0] pmin;
  logic [PERIOD_W-1:0] p_eff;
  logic [LENGTH-1:0]   delta;

  // The period floor guarantees the timer never expires before the FSM is back in WAIT.
  assign pl_eff = (pulse_len == 4'd0) ? 4'd1 : pulse_len;
  assign pmin   = PERIOD_W'(pl_eff) + PER_OVH;
  assign p_eff  = (period < pmin) ? pmin : period;
  assign delta  = cycle_count - prev_q;

  assign res_if.result       = result_q;
  assign res_if.result_valid = rv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ph_q          <= '0;
      per_q         <= '0;
      s0_q          <= '0;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      result_q      <= '0;
      rv_q          <= 1'b0;
      overrun       <= 1'b0;
      glitch        <= 1'b0;
      counter_reset <= 1'b0;
      latch_counter <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      per_q         <= per_d;
      s0_q          <= s0_d;
      prev_q        <= prev_d;
      prev_valid_q  <= prev_valid_d;
      result_q      <= result_d;
      rv_q          <= rv_d;
      overrun       <= overrun_d;
      glitch        <= glitch_d;
      counter_reset <= counter_reset_d;
      latch_counter <= latch_counter_d;
      busy          <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    per_d        = per_q;
    s0_d         = s0_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    result_d     = result_q;
    rv_d         = rv_q;
    overrun_d    = overrun;
    glitch_d     = glitch;

    if (rv_q && res_if.result_ready) rv_d = 1'b0;

    // Period timer free-runs through the gate states so latch edges stay P apart.
    if (state_q inside {S_LATCH, S_SETTLE, S_SAMPLE0, S_SAMPLE1} && per_q != '0)
      per_d = per_q - PER_ONE;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_CLR;
          ph_d    = PH_RST;
        end
      end
      S_CLR: begin
        per_d        = p_eff - PER_ONE;
        prev_valid_d = 1'b0;
        if (ph_q == '0) state_d = S_WAIT;
        else            ph_d    = ph_q - PH_ONE;
      end
      S_WAIT: begin
        if (per_q == '0) begin
          state_d = S_LATCH;
          per_d   = p_eff - PER_ONE;
          ph_d    = PH_W'(pl_eff - 4'd1);
        end else begin
          per_d = per_q - PER_ONE;
        end
      end
      S_LATCH: begin
        if (ph_q == '0) begin
          state_d = S_SETTLE;
          ph_d    = PH_SET;
        end else begin
          ph_d = ph_q - PH_ONE;
        end
      end
      S_SETTLE: begin
        if (ph_q == '0) state_d = S_SAMPLE0;
        else            ph_d    = ph_q - PH_ONE;
      end
      S_SAMPLE0: begin
        s0_d    = cycle_count;
        state_d = S_SAMPLE1;
      end
      S_SAMPLE1: begin
        state_d = S_WAIT;
        if (s0_q != cycle_count) begin
          glitch_d     = 1'b1;
          prev_valid_d = 1'b0;
        end else begin
          prev_d       = cycle_count;
          prev_valid_d = 1'b1;
          if (prev_valid_q) begin
            if (!rv_q || res_if.result_ready) begin
              result_d = delta;
              rv_d     = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!enable) begin
      state_d   = S_IDLE;
      rv_d      = 1'b0;
      overrun_d = 1'b0;
      glitch_d  = 1'b0;
    end

    counter_reset_d = (state_d == S_CLR);
    latch_counter_d = (state_d == S_LATCH);
    busy_d          = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_fmeas_gate_controller.sv
// Scoreboard bench for fmeas_gate_controller: a counter model feeds cycle_count,
// expected deltas are queued at each latch edge and compared on every handshake.
module tb_fmeas_gate_controller;
  localparam int LENGTH   = 20;
  localparam int PERIOD_W = 24;
  localparam int SETTLE_C = 4;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [PERIOD_W-1:0] period;
  logic [3:0]          pulse_len;
  logic [LENGTH-1:0]   cycle_count;
  logic                counter_reset;
  logic                latch_counter;
  logic                overrun;
  logic                glitch;
  logic                busy;

  fmeas_gate_if #(.LENGTH(LENGTH)) rif ();

  fmeas_gate_controller #(
    .LENGTH(LENGTH), .PERIOD_W(PERIOD_W), .SETTLE(SETTLE_C), .RST_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .pulse_len(pulse_len), .cycle_count(cycle_count),
    .counter_reset(counter_reset), .latch_counter(latch_counter),
    .res_if(rif), .overrun(overrun), .glitch(glitch), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Counter model and scoreboard controls
  logic [LENGTH-1:0] sb[$];
  int                inc = 250;
  bit                load_req = 0;
  logic [LENGTH-1:0] load_val = '0;
  bit                glitch_req = 0;
  int                pl_b = 2;
  logic              model_pv = 1'b0;
  logic [LENGTH-1:0] model_prev = '0;
  int                gl_k = 0;
  logic              lc_p = 1'b0;
  logic              rv_p = 1'b0;
  int                last_rise = 0;
  logic [LENGTH-1:0] exp_v;

  initial cycle_count = '0;

  // Monitor runs before the model so a latency check never sees a same-edge latch update.
  always @(negedge clk) begin
    if (rst_n && rif.result_valid && !rv_p)
      check("latency", cyc - last_rise, pl_b + SETTLE_C + 2);
    if (rst_n && rif.result_valid && rif.result_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_v = sb.pop_front();
        n_pop++;
        check("result", rif.result, exp_v);
      end
    end
    rv_p = rif.result_valid;

    if (!rst_n || counter_reset) model_pv = 1'b0;
    if (gl_k > 0) begin
      gl_k--;
      if (gl_k == 0) cycle_count = cycle_count + 20'd7;
    end
    if (latch_counter && !lc_p) begin
      last_rise = cyc;
      if (load_req) begin
        cycle_count = load_val;
        load_req    = 0;
      end else begin
        cycle_count = cycle_count + LENGTH'(inc);
      end
      if (glitch_req) begin
        glitch_req = 0;
        gl_k       = pl_b + SETTLE_C + 1;
        model_pv   = 1'b0;
      end else begin
        if (model_pv) sb.push_back(cycle_count - model_prev);
        model_prev = cycle_count;
        model_pv   = 1'b1;
      end
    end
    lc_p = latch_counter;
  end

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rif.result_ready = v;
  endtask

  task automatic wait_rise(input int budget, output int t);
    logic p;
    bit   seen;
    p    = latch_counter;
    seen = 0;
    t    = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (latch_counter && !p) begin
        seen = 1;
        t    = cyc;
      end
      p = latch_counter;
    end
    if (!seen) check("rise_timeout", 0, 1);
  endtask

  task automatic check_clr();
    int n;
    bit seen;
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      seen = counter_reset;
    end
    if (!seen) check("clr_start", 0, 1);
    check("busy_clr", busy, 1);
    n = 0;
    while (counter_reset && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("clr_len", n, 8);
  endtask

  task automatic stop_run();
    enable = 1'b0;
    gap(2);
    #1;
    check("off_busy", busy, 0);
    check("off_valid", rif.result_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, p0;
    logic [LENGTH-1:0] held;

    rst_n = 1'b0;
    enable = 1'b0;
    period = 24'd100;
    pulse_len = 4'd2;
    rif.result_ready = 1'b1;
    gap(3);
    check("rst_counter_reset", counter_reset, 0);
    check("rst_latch", latch_counter, 0);
    check("rst_valid", rif.result_valid, 0);
    check("rst_result", rif.result, 0);
    check("rst_overrun", overrun, 0);
    check("rst_glitch", glitch, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    gap(1);

    // Normal run: 250 counts per gate, first gate discarded
    p0 = n_pop;
    enable = 1'b1;
    check_clr();
    wait_rise(150, t0);
    gap(12);
    check("first_gate_novalid", rif.result_valid, 0);
    wait_rise(120, t1);
    check("spacing", t1 - t0, 100);
    wait_rise(120, t2);
    check("spacing", t2 - t1, 100);
    wait_rise(120, t1);
    check("spacing", t1 - t2, 100);
    gap(20);
    check("normal_pops", n_pop - p0, 3);
    stop_run();
    #1 check("normal_drain", sb.size(), 0);
    sb.delete();

    // Wrap-around delta
    load_req = 1;
    load_val = 20'hFFF00;
    enable = 1'b1;
    wait_rise(150, t0);
    gap(1);
    load_req = 1;
    load_val = 20'h000E0;
    wait_rise(120, t1);
    gap(12);
    check("wrap_result", rif.result, 20'h001E0);
    stop_run();
    sb.delete();

    // Backpressure: second delta dropped, first held
    enable = 1'b1;
    wait_rise(150, t0);
    wait_rise(120, t1);
    gap(12);
    set_ready(1'b0);
    wait_rise(120, t1);
    gap(12);
    check("bp_first_valid", rif.result_valid, 1);
    check("bp_first_result", rif.result, 250);
    held = rif.result;
    wait_rise(120, t1);
    gap(12);
    check("bp_overrun", overrun, 1);
    check("bp_still_valid", rif.result_valid, 1);
    check("bp_held", rif.result, held);
    set_ready(1'b1);
    gap(2);
    check("bp_valid_drop", rif.result_valid, 0);
    check("bp_overrun_sticky", overrun, 1);
    wait_rise(120, t1);
    gap(12);
    check("bp_overrun_sticky2", overrun, 1);
    stop_run();
    check("bp_overrun_clear", overrun, 0);
    check("bp_leftover", sb.size(), 1);
    sb.delete();

    // Glitch between the two samples
    enable = 1'b1;
    wait_rise(150, t0);
    wait_rise(120, t1);
    gap(12);
    glitch_req = 1;
    wait_rise(120, t1);
    gap(12);
    check("glitch_set", glitch, 1);
    check("glitch_nores", rif.result_valid, 0);
    p0 = n_pop;
    wait_rise(120, t1);
    gap(12);
    check("glitch_discard", n_pop - p0, 0);
    wait_rise(120, t1);
    gap(12);
    check("glitch_recover", n_pop - p0, 1);
    check("glitch_sticky", glitch, 1);
    stop_run();
    check("glitch_clear", glitch, 0);
    sb.delete();

    // Period clamp
    period = 24'd3;
    enable = 1'b1;
    wait_rise(60, t0);
    wait_rise(20, t1);
    check("clamp_spacing", t1 - t0, 9);
    wait_rise(20, t2);
    check("clamp_spacing", t2 - t1, 9);
    stop_run();
    sb.delete();

    pulse_len = 4'd0;
    pl_b = 1;
    enable = 1'b1;
    wait_rise(60, t0);
    gap(1);
    check("pl0_width", latch_counter, 0);
    wait_rise(20, t1);
    check("pl0_spacing", t1 - t0, 8);
    stop_run();
    sb.delete();

    // Async reset mid-latch
    pulse_len = 4'd2;
    pl_b = 2;
    period = 24'd100;
    enable = 1'b1;
    wait_rise(150, t0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_latch", latch_counter, 0);
    check("arst_busy", busy, 0);
    check("arst_counter_reset", counter_reset, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_clr();
    stop_run();
    sb.delete();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/fmeas_gate_controller.md
Name: fmeas_gate_controller

Overview:
Reference-clock-domain controller that drives the gate side of the frequency counter. It generates the counter reset and periodic latch pulses, samples the latched cycle count after a settle window, and outputs the per-gate count delta over a valid/ready handshake. Sits between the reference clock (1PPS-derived or crystal) and the measured-clock counter.

Parameters:
LENGTH, 20, width of the cycle_count input and result
PERIOD_W, 24, width of the gate period setting
SETTLE, 4, reference clocks between latch pulse end and first sample
RST_CYCLES, 8, reference clocks counter_reset is held high at start

Ports:
clk  in  1  reference clock
rst_n  in  1  asynchronous reset, active low
enable  in  1  level; 1 = run measurements, 0 = idle
period  in  PERIOD_W  spacing between latch rising edges, in clk cycles
pulse_len  in  4  latch_counter high time, in clk cycles
cycle_count  in  LENGTH  latched count from the counter (measured-clock domain)
counter_reset  out  1  reset request to the counter
latch_counter  out  1  latch request to the counter
result  out  LENGTH  count delta for the last gate
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
overrun  out  1  sticky: result dropped under backpressure
glitch  out  1  sticky: unstable sample detected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, async): state IDLE; all outputs 0; prev_valid=0; timers 0.
- All outputs registered. pulse_len=0 is treated as 1. Effective period P = max(period, PMIN) with PMIN = pulse_len+SETTLE+3.
- FSM states: IDLE, CLR, WAIT, LATCH, SETTLE, SAMPLE0, SAMPLE1.
- IDLE: enable=1 -> CLR next cycle.
- CLR: counter_reset=1 for exactly RST_CYCLES cycles, then WAIT. Period timer loaded with P-1. prev_valid cleared.
- WAIT: timer decrements. At 0 -> LATCH; timer reloads with P-1 on the same edge. Latch rising edges are therefore spaced exactly P cycles apart.
- LATCH: latch_counter=1 for pulse_len cycles -> SETTLE.
- SETTLE: SETTLE cycles -> SAMPLE0.
- SAMPLE0: capture s0=cycle_count -> SAMPLE1.
- SAMPLE1: capture s1=cycle_count, then return to WAIT (timer keeps running). Outcomes:
  - s0 != s1: glitch set; no result; prev_valid cleared.
  - s0 == s1 and prev_valid=0: prev=s1; prev_valid set; no result. The first gate after CLR is always discarded.
  - s0 == s1 and prev_valid=1: delta = s1 - prev mod 2^LENGTH (wrap-safe); prev=s1.
- Delta delivery:
  - If result_valid=0 or result_ready=1 in that cycle: result=delta, result_valid=1 next cycle.
  - Otherwise: delta dropped, old result held, overrun set.
  - Latency from latch rising edge to result_valid = pulse_len+SETTLE+2 cycles.
- Handshake: result is stable while result_valid=1 and result_ready=0. result_valid clears the cycle after result_valid and result_ready are both high, unless a new delta loads in that same cycle.
- enable=0 in any state: next cycle state=IDLE; counter_reset, latch_counter and result_valid go to 0; overrun and glitch clear. An in-flight sample is abandoned. Re-enable restarts from CLR.
- period/pulse_len are sampled when a timer loads, so changes apply from the next gate.
- rst_n asserted mid-operation: all outputs 0 immediately, including latch_counter mid-pulse.

Test Plan:
- Normal run: period=100, pulse_len=2, bench model adds 250 to cycle_count at each latch -> counter_reset high 8 cycles; latch rises every 100 cycles; first gate gives no result; then result=250 each gate, valid 8 cycles after each latch rise.
- Wrap: model prev=0xFFF00, next=0x000E0 -> result=0x001E0.
- Backpressure: result_ready=0 across two gates -> first result held unchanged, overrun=1; with ready=1, valid drops after one cycle and overrun stays 1 until enable=0.
- Glitch: bench changes cycle_count between SAMPLE0 and SAMPLE1 -> glitch=1, no result that gate, next gate discarded, following gate gives valid result=250.
- Period clamp: period=3, pulse_len=2 -> latch rising edges 9 cycles apart (PMIN=2+4+3); pulse_len=0 -> 1-cycle latch pulse.
- Async reset during LATCH: rst_n low mid-pulse -> latch_counter=0 without waiting for a clock edge; busy=0; after release with enable=1, the CLR sequence repeats.
